// File: rtl/dac_ctrl_pkg.sv
// Shared types and helpers for the DAC output path.
package dac_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } dac_state_t;

    // Index width that stays at least one bit wide for degenerate sizes.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dac_fifo.sv
// Small synchronous FIFO of DAC codes, first-word-fall-through read, with flush.
module dac_fifo
    import dac_ctrl_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [W-1:0]               wr_data,
    input  logic                       rd_en,
    output logic [W-1:0]               rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = width_of(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr && !flush) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/dac_ctrl.sv
// Buffers signed filter results, converts them to offset-binary DAC codes and
// paces them out to a parallel DAC at a programmable update rate.
module dac_ctrl
    import dac_ctrl_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int DAC_W = 8,
    parameter int SHIFT = 8,
    parameter int DIV   = 4,
    parameter int DEPTH = 4,
    parameter int PRIME = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic signed [IN_W-1:0]  in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DAC_W-1:0]        dac_data,
    output logic                    clk_dac,
    output logic                    underrun
);

    localparam int CW = width_of(DIV);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [DAC_W-1:0] MID_SCALE = {1'b1, {(DAC_W-1){1'b0}}};

    dac_state_t        state;
    dac_state_t        state_nxt;
    logic              enable_q;
    logic [CW-1:0]     cnt;
    logic              tick;
    logic              pop;
    logic              push;
    logic [DAC_W-1:0]  code;
    logic [DAC_W-1:0]  rd_data;
    logic              full;
    logic              empty;
    logic [LW-1:0]     level;

    // Shift, clamp to the signed DAC range, then flip the MSB for offset binary.
    function automatic logic [DAC_W-1:0] to_code(input logic signed [IN_W-1:0] x);
        logic signed [IN_W-1:0] s;
        logic signed [IN_W-1:0] hi;
        logic signed [IN_W-1:0] lo;
        hi = {{(IN_W-DAC_W+1){1'b0}}, {(DAC_W-1){1'b1}}};
        lo = {{(IN_W-DAC_W+1){1'b1}}, {(DAC_W-1){1'b0}}};
        s  = x >>> SHIFT;
        if (s > hi)      s = hi;
        else if (s < lo) s = lo;
        return {~s[DAC_W-1], s[DAC_W-2:0]};
    endfunction

    assign in_ready = enable_q & ~full;
    assign push     = in_valid & in_ready;
    assign code     = to_code(in_data);
    assign clk_dac  = ~clk;

    dac_fifo #(
        .W     (DAC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (~enable_q),
        .wr_en   (push),
        .wr_data (code),
        .rd_en   (pop),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            enable_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            enable_q <= enable;
        end
    end

    always_comb begin
        state_nxt = state;
        tick      = (state == ST_RUN) && (cnt == CW'(DIV - 1));
        pop       = tick & ~empty;
        case (state)
            ST_IDLE:  if (enable_q) state_nxt = ST_PRIME;
            ST_PRIME: if (level >= LW'(PRIME)) state_nxt = ST_RUN;
            ST_RUN:   state_nxt = ST_RUN;
            default:  state_nxt = ST_IDLE;
        endcase
        if (!enable_q) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            dac_data <= MID_SCALE;
            underrun <= 1'b0;
        end else begin
            if (state == ST_RUN) cnt <= tick ? '0 : cnt + 1'b1;
            else                 cnt <= '0;

            if (!enable_q || state == ST_IDLE) dac_data <= MID_SCALE;
            else if (pop)                      dac_data <= rd_data;

            // Sticky until the next start from IDLE.
            if (state == ST_IDLE && enable_q) underrun <= 1'b0;
            else if (tick && empty)           underrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dac_ctrl.sv
// Directed bench for dac_ctrl: two instances cover the SHIFT=8/PRIME=2 and
// SHIFT=4/PRIME=4 configurations.
module tb_dac_ctrl;

    logic              clk;
    logic              rst_n;

    logic              enable_a, in_valid_a, in_ready_a, clk_dac_a, underrun_a;
    logic signed [15:0] in_data_a;
    logic [7:0]        dac_a;

    logic              enable_b, in_valid_b, in_ready_b, clk_dac_b, underrun_b;
    logic signed [15:0] in_data_b;
    logic [7:0]        dac_b;

    int n_chk;
    int n_pass;

    dac_ctrl #(.IN_W(16), .DAC_W(8), .SHIFT(8), .DIV(4), .DEPTH(4), .PRIME(2)) u_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable_a),
        .in_data  (in_data_a),
        .in_valid (in_valid_a),
        .in_ready (in_ready_a),
        .dac_data (dac_a),
        .clk_dac  (clk_dac_a),
        .underrun (underrun_a)
    );

    dac_ctrl #(.IN_W(16), .DAC_W(8), .SHIFT(4), .DIV(4), .DEPTH(4), .PRIME(4)) u_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable_b),
        .in_data  (in_data_b),
        .in_valid (in_valid_b),
        .in_ready (in_ready_b),
        .dac_data (dac_b),
        .clk_dac  (clk_dac_b),
        .underrun (underrun_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a negedge; returns on the negedge after the accepting posedge.
    task automatic push_a(input logic [15:0] d);
        int n;
        n = 0;
        in_data_a  = d;
        in_valid_a = 1'b1;
        while (!in_ready_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("push_a_timeout", 16'(n), 16'd0);
        @(negedge clk);
        in_valid_a = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst_n = 1'b0;
        enable_a = 1'b0; in_valid_a = 1'b0; in_data_a = '0;
        enable_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0;
        cyc(2);

        chk("rst_dac_a",      16'(dac_a),      16'h80);
        chk("rst_dac_b",      16'(dac_b),      16'h80);
        chk("rst_underrun_a", 16'(underrun_a), 16'h0);
        chk("rst_in_ready_a", 16'(in_ready_a), 16'h0);
        chk("clk_dac_inv",    16'(clk_dac_a),  16'h1);
        rst_n = 1'b1;
        cyc(1);

        // Saturation and backpressure on u_b (SHIFT=4, PRIME=4), N0 here.
        enable_b = 1'b1;
        cyc(1);
        chk("b_ready_en", 16'(in_ready_b), 16'h1);
        in_valid_b = 1'b1; in_data_b = 16'sh7FFF;
        cyc(1); in_data_b = 16'sh8000;
        cyc(1); in_data_b = 16'sh0070;
        cyc(1); in_data_b = 16'sh0010;
        cyc(1); in_data_b = 16'sh0300;
        chk("b_full_ready", 16'(in_ready_b), 16'h0);
        cyc(4);
        chk("b_full_hold", 16'(in_ready_b), 16'h0);
        chk("b_prime_mid", 16'(dac_b),      16'h80);
        cyc(1);
        chk("b_pushpop_ready", 16'(in_ready_b), 16'h1);
        chk("b_sat_pos",       16'(dac_b),      16'hFF);
        in_valid_b = 1'b0;
        cyc(3);
        chk("b_hold_ff", 16'(dac_b), 16'hFF);
        cyc(1);
        chk("b_sat_neg", 16'(dac_b), 16'h00);
        cyc(4);
        chk("b_code_87", 16'(dac_b), 16'h87);
        cyc(4);
        chk("b_code_81", 16'(dac_b), 16'h81);
        cyc(3);
        chk("b_no_underrun", 16'(underrun_b), 16'h0);
        cyc(1);
        chk("b_underrun",    16'(underrun_b), 16'h1);
        chk("b_no_5th_word", 16'(dac_b),      16'h81);
        enable_b = 1'b0;
        cyc(1);

        // Basic conversion and pacing on u_a (SHIFT=8, PRIME=2), N0 here.
        enable_a = 1'b1;
        cyc(1);
        push_a(16'h1234);
        push_a(16'hFF00);
        chk("a_prime_mid", 16'(dac_a), 16'h80);
        cyc(4);
        chk("a_before_pop", 16'(dac_a), 16'h80);
        cyc(1);
        chk("a_code_92", 16'(dac_a), 16'h92);
        cyc(3);
        chk("a_hold_92", 16'(dac_a), 16'h92);
        cyc(1);
        chk("a_code_7f", 16'(dac_a), 16'h7F);
        cyc(3);
        chk("a_hold_7f",     16'(dac_a),      16'h7F);
        chk("a_no_underrun", 16'(underrun_a), 16'h0);
        cyc(1);
        chk("a_underrun",      16'(underrun_a), 16'h1);
        chk("a_underrun_hold", 16'(dac_a),      16'h7F);
        cyc(5);
        chk("a_underrun_sticky", 16'(underrun_a), 16'h1);

        // Enable toggle returns to mid-scale and rearms the underrun flag.
        enable_a = 1'b0;
        cyc(2);
        chk("a_dis_mid",    16'(dac_a),      16'h80);
        chk("a_dis_sticky", 16'(underrun_a), 16'h1);
        enable_a = 1'b1;
        cyc(2);
        chk("a_reen_clear", 16'(underrun_a), 16'h0);
        chk("a_reen_mid",   16'(dac_a),      16'h80);

        // A single word must not leave PRIME.
        push_a(16'h0100);
        cyc(10);
        chk("a_single_prime", 16'(dac_a), 16'h80);
        push_a(16'h0200);
        cyc(4);
        chk("a_run_cnt3", 16'(dac_a), 16'h80);
        cyc(1);
        chk("a_first_pop", 16'(dac_a), 16'h81);

        // Asynchronous reset with three words queued.
        push_a(16'h0300);
        push_a(16'h0400);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_dac",   16'(dac_a),      16'h80);
        chk("rst_mid_ready", 16'(in_ready_a), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(12);
        chk("rst_no_stale",  16'(dac_a),      16'h80);
        chk("rst_ready_back", 16'(in_ready_a), 16'h1);
        push_a(16'h0500);
        push_a(16'h0600);
        cyc(4);
        chk("rst_pre_pop", 16'(dac_a), 16'h80);
        cyc(1);
        chk("rst_fresh_word", 16'(dac_a), 16'h85);
        cyc(4);
        chk("rst_second_word", 16'(dac_a), 16'h86);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
